// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its instruction decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CLS_ARITH,
    CLS_LOGIC,
    CLS_SHIFT,
    CLS_MULDIV,
    CLS_MFHI,
    CLS_MFLO,
    CLS_ADDI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_NONE
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_MULT = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_PC4  = 4'b1011;

  localparam logic [1:0] SIGN_ADDU = 2'b00;
  localparam logic [1:0] SIGN_SUBU = 2'b01;
  localparam logic [1:0] SIGN_ADD  = 2'b10;
  localparam logic [1:0] SIGN_SUB  = 2'b11;

  localparam int FLAG_V = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_HI  = 2'b10;
  localparam logic [1:0] WB_LO  = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCA_RS     = 2'b00;
  localparam logic [1:0] SRCA_SHAMT  = 2'b01;
  localparam logic [1:0] SRCA_IMM_ZX = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_IMM_SX = 2'b01;
  localparam logic [1:0] SRCB_PC     = 2'b10;

  // Only signed add/sub (ADD, SUB, ADDI) may trap on overflow; MULT shares sign 10 but not op 0001.
  function automatic logic needs_ovf_check(input logic [3:0] op, input logic [1:0] sign);
    return (op == ALU_ADD) && sign[1];
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of opcode/funct into an instruction class and the EXECUTE-cycle ALU controls.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic [3:0]   alu_op,
  output logic [1:0]   alu_sign,
  output logic [1:0]   alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic         valid
);

  always_comb begin
    cls       = CLS_NONE;
    alu_op    = ALU_NOP;
    alu_sign  = SIGN_ADDU;
    alu_src_a = SRCA_RS;
    alu_src_b = SRCB_RT;
    valid     = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:   begin cls = CLS_ARITH;  alu_op = ALU_ADD;  alu_sign = SIGN_ADD;  end
          FN_ADDU:  begin cls = CLS_ARITH;  alu_op = ALU_ADD;  alu_sign = SIGN_ADDU; end
          FN_SUB:   begin cls = CLS_ARITH;  alu_op = ALU_ADD;  alu_sign = SIGN_SUB;  end
          FN_SUBU:  begin cls = CLS_ARITH;  alu_op = ALU_ADD;  alu_sign = SIGN_SUBU; end
          FN_AND:   begin cls = CLS_LOGIC;  alu_op = ALU_AND;  end
          FN_OR:    begin cls = CLS_LOGIC;  alu_op = ALU_OR;   end
          FN_NOR:   begin cls = CLS_LOGIC;  alu_op = ALU_NOR;  end
          FN_SLL:   begin cls = CLS_SHIFT;  alu_op = ALU_SLL;  alu_src_a = SRCA_SHAMT; end
          FN_SRL:   begin cls = CLS_SHIFT;  alu_op = ALU_SRL;  alu_src_a = SRCA_SHAMT; end
          FN_SRA:   begin cls = CLS_SHIFT;  alu_op = ALU_SRA;  alu_src_a = SRCA_SHAMT; end
          FN_MULT:  begin cls = CLS_MULDIV; alu_op = ALU_MULT; alu_sign = SIGN_ADD;  end
          FN_MULTU: begin cls = CLS_MULDIV; alu_op = ALU_MULT; alu_sign = SIGN_ADDU; end
          FN_DIV:   begin cls = CLS_MULDIV; alu_op = ALU_DIV;  alu_sign = SIGN_ADD;  end
          FN_DIVU:  begin cls = CLS_MULDIV; alu_op = ALU_DIV;  alu_sign = SIGN_ADDU; end
          FN_MFHI:  begin cls = CLS_MFHI;   alu_op = ALU_NOP;  end
          FN_MFLO:  begin cls = CLS_MFLO;   alu_op = ALU_NOP;  end
          default:  valid = 1'b0;
        endcase
      end
      OP_ADDI:  begin cls = CLS_ADDI; alu_op = ALU_ADD; alu_sign = SIGN_ADD;  alu_src_b = SRCB_IMM_SX; end
      OP_ADDIU: begin cls = CLS_ADDI; alu_op = ALU_ADD; alu_sign = SIGN_ADDU; alu_src_b = SRCB_IMM_SX; end
      OP_LUI:   begin cls = CLS_LUI;  alu_op = ALU_LUI; alu_src_a = SRCA_IMM_ZX; end
      OP_LW:    begin cls = CLS_LW;   alu_op = ALU_ADD; alu_src_b = SRCB_IMM_SX; end
      OP_SW:    begin cls = CLS_SW;   alu_op = ALU_ADD; alu_src_b = SRCB_IMM_SX; end
      OP_BEQ:   begin cls = CLS_BEQ;  alu_op = ALU_ADD; alu_sign = SIGN_SUBU; end
      OP_J:     begin cls = CLS_J; end
      default:  valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_control_fsm.sv
// Multi-cycle CPU control unit: fetch/decode/execute/memory/writeback sequencing with a sticky trap.
module alu_control_fsm
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [3:0] flags,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_load,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic [1:0] alu_sign,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_we,
  output logic       reg_dst,
  output logic [1:0] wb_sel,
  output logic       hilo_we,
  output logic       trap
);

  state_t       state, next_state;
  instr_class_t cls;
  logic [3:0]   dec_op;
  logic [1:0]   dec_sign, dec_src_a, dec_src_b;
  logic         dec_valid;
  logic         overflow_trap;
  logic         unused_flags;

  instr_decoder u_decoder (
    .opcode    (opcode),
    .funct     (funct),
    .cls       (cls),
    .alu_op    (dec_op),
    .alu_sign  (dec_sign),
    .alu_src_a (dec_src_a),
    .alu_src_b (dec_src_b),
    .valid     (dec_valid)
  );

  assign overflow_trap = needs_ovf_check(dec_op, dec_sign) && flags[FLAG_V];
  assign unused_flags  = ^{flags[FLAG_N], flags[FLAG_C]};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (mem_ack) next_state = S_DECODE;
      S_DECODE: next_state = dec_valid ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if (overflow_trap) next_state = S_TRAP;
        else begin
          case (cls)
            CLS_MULDIV, CLS_BEQ, CLS_J: next_state = S_FETCH;
            CLS_LW, CLS_SW:             next_state = S_MEMORY;
            CLS_NONE:                   next_state = S_TRAP;
            default:                    next_state = S_WRITEBACK;
          endcase
        end
      end
      S_MEMORY:    if (mem_ack) next_state = (cls == CLS_SW) ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: next_state = S_FETCH;
      S_TRAP:      next_state = S_TRAP;
      default:     next_state = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing pending leaks out before the IDLE edge.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    pc_src    = PC_ALU;
    alu_op    = ALU_NOP;
    alu_sign  = SIGN_ADDU;
    alu_src_a = SRCA_RS;
    alu_src_b = SRCB_RT;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = WB_ALU;
    hilo_we   = 1'b0;
    trap      = 1'b0;
    if (reset_n) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_op    = ALU_PC4;
          alu_src_b = SRCB_PC;
          if (mem_ack) begin
            ir_load = 1'b1;
            pc_load = 1'b1;
            pc_src  = PC_ALU;
          end
        end
        S_EXECUTE: begin
          alu_op    = dec_op;
          alu_sign  = dec_sign;
          alu_src_a = dec_src_a;
          alu_src_b = dec_src_b;
          case (cls)
            CLS_MULDIV: hilo_we = 1'b1;
            CLS_BEQ: begin
              if (flags[FLAG_Z]) begin
                pc_load = 1'b1;
                pc_src  = PC_BRANCH;
              end
            end
            CLS_J: begin
              pc_load = 1'b1;
              pc_src  = PC_JUMP;
            end
            default: ;
          endcase
        end
        S_MEMORY: begin
          mem_req = 1'b1;
          mem_we  = (cls == CLS_SW);
        end
        S_WRITEBACK: begin
          reg_we = 1'b1;
          case (cls)
            CLS_MFHI:          wb_sel = WB_HI;
            CLS_MFLO:          wb_sel = WB_LO;
            CLS_ADDI, CLS_LUI: reg_dst = 1'b1;
            CLS_LW: begin
              wb_sel  = WB_MEM;
              reg_dst = 1'b1;
            end
            default: ;
          endcase
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
